// File: rtl/smin_window.sv
// smin_window: streaming signed-minimum reducer.
// Accepts a valid/ready stream of signed WIDTH-bit samples. It groups them
// into windows of up to WINDOW samples. For each window it emits one result
// beat: the minimum value, the 0-based index of its first occurrence, and the
// sample count. in_last closes a window early.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   sample offered
//   in_ready   block can take a sample this cycle (depends on the output slot only)
//   in_data    signed sample
//   in_last    closes the window with this sample
//   out_valid  result beat held
//   out_ready  consumer takes the result this cycle
//   out_min    signed minimum of the window
//   out_idx    index of the first minimum
//   out_count  number of samples in the window, 1..WINDOW
module smin_window #(
   parameter int WIDTH  = 16,
   parameter int WINDOW = 8,
   parameter int IDXW   = $clog2(WINDOW)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  in_data,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  out_min,
   output logic [IDXW-1:0]   out_idx,
   output logic [IDXW:0]     out_count
);

   localparam logic [IDXW-1:0] LASTIDX = IDXW'(WINDOW - 1);

   logic [IDXW-1:0]  cnt;
   logic [WIDTH-1:0] cur_min;
   logic [IDXW-1:0]  cur_idx;

   logic             accept;
   logic             close;
   logic             take;
   logic [WIDTH-1:0] nxt_min;
   logic [IDXW-1:0]  nxt_idx;

   // The slot can take a new result when it is empty or is being drained now.
   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;
   assign close    = accept && (in_last || (cnt == LASTIDX));

   // The first sample of a window always seeds the accumulator. A strict
   // compare keeps the earliest index on ties.
   always_comb begin
      take    = (cnt == '0) || ($signed(in_data) < $signed(cur_min));
      nxt_min = take ? in_data : cur_min;
      nxt_idx = take ? cnt     : cur_idx;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt       <= '0;
         cur_min   <= '0;
         cur_idx   <= '0;
         out_valid <= 1'b0;
         out_min   <= '0;
         out_idx   <= '0;
         out_count <= '0;
      end else begin
         if (accept) begin
            cur_min <= nxt_min;
            cur_idx <= nxt_idx;
            cnt     <= close ? '0 : cnt + 1'b1;
         end
         // A closing sample refills the slot even when the old beat drains
         // in this same cycle, so back-to-back windows have no bubble.
         if (close) begin
            out_valid <= 1'b1;
            out_min   <= nxt_min;
            out_idx   <= nxt_idx;
            out_count <= {1'b0, cnt} + (IDXW + 1)'(1);
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_smin_window.sv
module tb_smin_window;

   localparam int WIDTH  = 16;
   localparam int WINDOW = 4;
   localparam int IDXW   = $clog2(WINDOW);

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [WIDTH-1:0]  in_data = '0;
   logic              in_last = 1'b0;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic [WIDTH-1:0]  out_min;
   logic [IDXW-1:0]   out_idx;
   logic [IDXW:0]     out_count;

   int checks = 0;
   int errors = 0;

   smin_window #(.WIDTH(WIDTH), .WINDOW(WINDOW)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_min(out_min), .out_idx(out_idx), .out_count(out_count)
   );

   always #5 clk = ~clk;

   // Apply inputs, advance one rising edge, and return 1 time unit later.
   task automatic cyc(input logic v, input logic [WIDTH-1:0] d, input logic l);
      in_valid = v; in_data = d; in_last = l;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      #2;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
      checks++; if (out_min !== 16'h0000) begin errors++; $display("FAIL reset_min: got %h expected 0000", out_min); end
      checks++; if (out_idx !== 2'd0) begin errors++; $display("FAIL reset_idx: got %0d expected 0", out_idx); end
      checks++; if (out_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", out_count); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      #10; rst = 1'b0;
   endtask

   task automatic test_basic();
      logic [WIDTH-1:0] s [4];
      s[0] = 16'h0005; s[1] = 16'hFFFD; s[2] = 16'h0007; s[3] = 16'hFFFD;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, s[i], 1'b0);
         if (i < 3) begin
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid[%0d]: got %b expected 0", i, out_valid); end
         end
      end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", out_valid); end
      checks++; if (out_min !== 16'hFFFD) begin errors++; $display("FAIL basic_min: got %h expected fffd", out_min); end
      checks++; if (out_idx !== 2'd1) begin errors++; $display("FAIL basic_idx: got %0d expected 1", out_idx); end
      checks++; if (out_count !== 3'd4) begin errors++; $display("FAIL basic_count: got %0d expected 4", out_count); end
      cyc(1'b0, '0, 1'b0);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_one_cycle: got %b expected 0", out_valid); end
   endtask

   task automatic test_early_close();
      out_ready = 1'b1;
      cyc(1'b1, 16'h7FFF, 1'b0);
      cyc(1'b1, 16'h8000, 1'b1);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL early_valid: got %b expected 1", out_valid); end
      checks++; if (out_min !== 16'h8000) begin errors++; $display("FAIL early_min: got %h expected 8000", out_min); end
      checks++; if (out_idx !== 2'd1) begin errors++; $display("FAIL early_idx: got %0d expected 1", out_idx); end
      checks++; if (out_count !== 3'd2) begin errors++; $display("FAIL early_count: got %0d expected 2", out_count); end
      // Single-sample window right after: must restart at index 0.
      cyc(1'b1, 16'h0003, 1'b1);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", out_valid); end
      checks++; if (out_min !== 16'h0003) begin errors++; $display("FAIL single_min: got %h expected 0003", out_min); end
      checks++; if (out_idx !== 2'd0) begin errors++; $display("FAIL single_idx: got %0d expected 0", out_idx); end
      checks++; if (out_count !== 3'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", out_count); end
      cyc(1'b0, '0, 1'b0);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drain: got %b expected 0", out_valid); end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      cyc(1'b1, 16'h0004, 1'b0);
      cyc(1'b1, 16'h0002, 1'b1);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b expected 1", out_valid); end
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; in_data = 16'h0064; in_last = 1'b1;
         #1;
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", i, in_ready); end
         @(posedge clk); #1;
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid[%0d]: got %b expected 1", i, out_valid); end
         checks++; if (out_min !== 16'h0002) begin errors++; $display("FAIL bp_hold_min[%0d]: got %h expected 0002", i, out_min); end
         checks++; if (out_idx !== 2'd1) begin errors++; $display("FAIL bp_hold_idx[%0d]: got %0d expected 1", i, out_idx); end
         checks++; if (out_count !== 3'd2) begin errors++; $display("FAIL bp_hold_count[%0d]: got %0d expected 2", i, out_count); end
      end
      in_valid = 1'b0; in_last = 1'b0;
      out_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready: got %b expected 1", in_ready); end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_consumed: got %b expected 0", out_valid); end
   endtask

   // Also proves the stalled samples were dropped: a stray accept would
   // shift the window boundary or the count.
   task automatic test_ties();
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) cyc(1'b1, 16'h0006, 1'b0);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ties_valid: got %b expected 1", out_valid); end
      checks++; if (out_min !== 16'h0006) begin errors++; $display("FAIL ties_min: got %h expected 0006", out_min); end
      checks++; if (out_idx !== 2'd0) begin errors++; $display("FAIL ties_idx: got %0d expected 0", out_idx); end
      checks++; if (out_count !== 3'd4) begin errors++; $display("FAIL ties_count: got %0d expected 4", out_count); end
      cyc(1'b0, '0, 1'b0);
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         in_valid = 1'b1; in_data = WIDTH'(i); in_last = 1'b0;
         checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_stall[%0d]: got %b expected 1", i, in_ready); end
         @(posedge clk); #1;
         if (i == 4 || i == 8) begin
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d]: got %b expected 1", i, out_valid); end
            checks++; if (out_min !== ((i == 4) ? 16'h0001 : 16'h0005)) begin errors++; $display("FAIL b2b_min[%0d]: got %h expected %h", i, out_min, (i == 4) ? 16'h0001 : 16'h0005); end
            checks++; if (out_idx !== 2'd0) begin errors++; $display("FAIL b2b_idx[%0d]: got %0d expected 0", i, out_idx); end
            checks++; if (out_count !== 3'd4) begin errors++; $display("FAIL b2b_count[%0d]: got %0d expected 4", i, out_count); end
         end else begin
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_gap[%0d]: got %b expected 0", i, out_valid); end
         end
      end
      cyc(1'b0, '0, 1'b0);
   endtask

   task automatic test_simultaneous();
      out_ready = 1'b1;
      cyc(1'b1, 16'h000A, 1'b1);
      checks++; if (out_min !== 16'h000A) begin errors++; $display("FAIL simul_first_min: got %h expected 000a", out_min); end
      in_valid = 1'b1; in_data = 16'h0008; in_last = 1'b1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL simul_in_ready: got %b expected 1", in_ready); end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL simul_valid: got %b expected 1", out_valid); end
      checks++; if (out_min !== 16'h0008) begin errors++; $display("FAIL simul_min: got %h expected 0008", out_min); end
      checks++; if (out_count !== 3'd1) begin errors++; $display("FAIL simul_count: got %0d expected 1", out_count); end
      cyc(1'b1, 16'hFFFE, 1'b1);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL simul2_valid: got %b expected 1", out_valid); end
      checks++; if (out_min !== 16'hFFFE) begin errors++; $display("FAIL simul2_min: got %h expected fffe", out_min); end
      cyc(1'b0, '0, 1'b0);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL simul_drain: got %b expected 0", out_valid); end
   endtask

   task automatic test_reset_mid();
      logic [WIDTH-1:0] s [4];
      s[0] = 16'h0009; s[1] = 16'h0002; s[2] = 16'h0004; s[3] = 16'h0003;
      out_ready = 1'b1;
      cyc(1'b1, 16'hFFFB, 1'b0);
      cyc(1'b1, 16'hFFFA, 1'b0);
      in_valid = 1'b0;
      #1 rst = 1'b1;
      #1;
      checks++; if (out_min !== 16'h0000) begin errors++; $display("FAIL rstmid_min: got %h expected 0000", out_min); end
      checks++; if (out_count !== 3'd0) begin errors++; $display("FAIL rstmid_count: got %0d expected 0", out_count); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b expected 0", out_valid); end
      #1 rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, s[i], 1'b0);
         if (i < 3) begin
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_early[%0d]: got %b expected 0", i, out_valid); end
         end
      end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_valid2: got %b expected 1", out_valid); end
      checks++; if (out_min !== 16'h0002) begin errors++; $display("FAIL rstmid_min2: got %h expected 0002", out_min); end
      checks++; if (out_idx !== 2'd1) begin errors++; $display("FAIL rstmid_idx2: got %0d expected 1", out_idx); end
      checks++; if (out_count !== 3'd4) begin errors++; $display("FAIL rstmid_count2: got %0d expected 4", out_count); end
      cyc(1'b0, '0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_early_close();
      test_backpressure();
      test_ties();
      test_back_to_back();
      test_simultaneous();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/smin_window.md
Name: smin_window

Overview:
- Streaming signed-minimum reducer; the sequential counterpart to the team's combinational smax compare.
- Consumes a valid/ready stream of signed WIDTH-bit samples.
- For each window of up to WINDOW samples, produces one result beat: minimum value, index of its first occurrence and sample count.
- Sits between a sample producer and the downstream result consumer, which may stall.

Parameters:
- WIDTH, 16, sample and result width; two's-complement signed.
- WINDOW, 8, maximum samples per window; legal range 2..256.
- IDXW, $clog2(WINDOW), width of the index field; derived, do not override.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  sample offered.
- in_ready  output  1  block can accept a sample this cycle.
- in_data  input  WIDTH  signed sample.
- in_last  input  1  closes the window early with this sample.
- out_valid  output  1  result beat held.
- out_ready  input  1  consumer accepts the result this cycle.
- out_min  output  WIDTH  signed minimum of the window.
- out_idx  output  IDXW  position of the first minimum, 0-based.
- out_count  output  IDXW+1  samples in the window, 1..WINDOW.

Behaviour:
- Reset, asynchronous, applied immediately on rst high:
  - out_valid=0, out_min=0, out_idx=0, out_count=0.
  - Accumulator cleared: cnt=0, cur_min=0, cur_idx=0.
  - state=ACC.
- Reset mid-window or mid-stall discards the partial window and any held result; no beat is emitted.
- Transfer rules:
  - Input handshake on in_valid && in_ready.
  - Output handshake on out_valid && out_ready.
  - in_ready = !out_valid || out_ready, a combinational function of the output slot only; never depends on in_valid.
- State ACC, on each accepted sample:
  - If cnt==0 or $signed(in_data) < $signed(cur_min): cur_min<=in_data, cur_idx<=cnt.
  - Compare is strict, so ties keep the earlier index.
  - If cnt==WINDOW-1 or in_last==1, the window closes:
    - Next cycle: out_min and out_idx take the post-update min and index, out_count=cnt+1, out_valid=1.
    - Accumulator resets to cnt=0 in the same edge.
  - Otherwise cnt<=cnt+1.
- Latency: result visible exactly one cycle after the closing sample is accepted.
- Throughput: one sample per cycle sustained while out_ready=1, including back-to-back windows with no bubble.
- Output slot:
  - Held stable (value and valid) while out_valid && !out_ready; in_ready=0 in that case.
  - On out_ready with no new closing sample, out_valid<=0 next cycle.
  - Simultaneous: output beat consumed and a new window closes in the same cycle → out_valid stays 1 with the new result.
- Boundaries:
  - Single-sample window (in_last on the first sample): out_count=1, out_idx=0, out_min=sample.
  - All-equal samples give out_idx=0.
  - Most-negative value 0x8000 (WIDTH=16) is the minimum over any other value.
  - Most-positive 0x7FFF never displaces a prior minimum.
- cnt never exceeds WINDOW-1; wrap to 0 only at window close.
- in_last on the WINDOW-th sample is redundant and produces one beat, not two.
- Inputs are ignored when in_ready=0; no sample is lost or duplicated.

Test Plan:
- WIDTH=16, WINDOW=4, out_ready=1:
  - Stimulus: samples 5, -3, 7, -3.
  - Response: one cycle after the 4th accept, out_min=0xFFFD, out_idx=1, out_count=4, out_valid for exactly one cycle.
- Early close:
  - Stimulus: samples 0x7FFF, 0x8000 with in_last on the 2nd.
  - Response: out_min=0x8000, out_idx=1, out_count=2; the following window starts at idx 0.
- Backpressure:
  - Stimulus: close a window with out_ready=0 for 5 cycles.
  - Response: in_ready=0 and the result is stable for all 5 cycles. Raising out_ready consumes it, and in_ready=1 in the same cycle.
- Back-to-back:
  - Stimulus: 8 continuous samples 1..8, WINDOW=4, out_ready=1.
  - Response: two beats {min=1, idx=0} and {min=5, idx=0}, no stall cycles.
- Reset mid-window:
  - Stimulus: 2 samples accepted, pulse rst asynchronously between edges.
  - Response: outputs zero immediately. The next 4 samples 9, 2, 4, 3 yield min=2, idx=1, count=4.
- Simultaneous consume and close:
  - Stimulus: out_valid=1 and out_ready=1 in the same cycle the closing sample is accepted.
  - Response: out_valid stays high and the new values appear next cycle with no gap.
